// File: rtl/axi4_slave_sram.sv
// ---------------------------------------------------------------------------
// axi4_slave_sram
//
// AXI4 slave memory sitting directly behind the PicoRV32 AXI4 master. Program
// and data live in an internal array of 32-bit words. The read and write
// channels each run their own state machine and accept one transaction at a
// time. Single beats and FIXED/INCR bursts of up to 256 beats are supported,
// with per-byte write strobes. Malformed or out-of-range accesses get SLVERR.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   s_axi_aw*             write address channel (id, addr, len, size, burst)
//   s_axi_w*              write data channel (data, strobe, last)
//   s_axi_b*              write response channel (id, resp)
//   s_axi_ar*             read address channel (id, addr, len, size, burst)
//   s_axi_r*              read data channel (id, data, resp, last)
// ---------------------------------------------------------------------------
module axi4_slave_sram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    aclk,
  input  logic                    areset,

  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,

  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,

  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,

  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,

  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_WORDS);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'b010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Contents are never reset so a core reset keeps program and data.
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Word index is taken at full address width so that an address below
  // BASE_ADDR wraps to a huge index and simply fails the range check.
  function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    return (addr - BASE_ADDR) >> 2;
  endfunction

  function automatic logic bad_request(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [2:0]            size,
                                       input logic [1:0]            burst);
    return (size != SIZE_WORD) ||
           ((burst != BURST_FIXED) && (burst != BURST_INCR)) ||
           (addr[1:0] != 2'b00);
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
    return idx < MEM_LIMIT;
  endfunction

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [1:0]            w_burst;
  logic                  w_err;

  logic aw_fire;
  logic w_fire;
  logic w_final;
  logic w_commit;

  assign aw_fire  = s_axi_awvalid && s_axi_awready;
  assign w_fire   = s_axi_wvalid && s_axi_wready;
  assign w_final  = (w_cnt == w_len);
  assign w_commit = w_fire && !w_err && in_range(w_idx);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // The burst length comes from AWLEN alone; WLAST is only checked, never
  // used to terminate the burst.
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Error is sticky over the burst: once a beat misses the array or WLAST
  // disagrees with the beat count, every later beat is dropped.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= BURST_FIXED;
      w_err   <= 1'b0;
    end else if (aw_fire) begin
      w_id    <= s_axi_awid;
      w_idx   <= word_index(s_axi_awaddr);
      w_len   <= s_axi_awlen;
      w_cnt   <= '0;
      w_burst <= s_axi_awburst;
      w_err   <= bad_request(s_axi_awaddr, s_axi_awsize, s_axi_awburst);
    end else if (w_fire) begin
      w_cnt <= w_cnt + 8'd1;
      if (w_burst == BURST_INCR) w_idx <= w_idx + 1'b1;
      if (!in_range(w_idx) || (s_axi_wlast != w_final)) w_err <= 1'b1;
    end
  end

  assign s_axi_bid   = w_id;
  assign s_axi_bresp = (s_axi_bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge aclk) begin
    if (w_commit) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx[IDX_WIDTH-1:0]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  r_state_t              r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;

  logic                  ar_fire;
  logic                  r_fire;
  logic                  r_final;
  logic                  r_load;
  logic [ADDR_WIDTH-1:0] ld_idx;
  logic                  ld_err;
  logic                  ld_last;
  logic                  ld_ok;

  assign ar_fire = s_axi_arvalid && s_axi_arready;
  assign r_fire  = s_axi_rvalid && s_axi_rready;
  assign r_final = (r_cnt == r_len);
  assign r_load  = ar_fire || (r_fire && !r_final);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && r_final) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Describes the beat that will be registered at the next load: the first
  // beat straight from AR while idle, otherwise the beat after the current
  // one. Loading the following beat on every handshake is what allows
  // back-to-back beats without a bubble.
  always_comb begin
    ld_idx  = r_idx;
    ld_err  = r_err;
    ld_last = 1'b0;
    if (r_state == R_IDLE) begin
      ld_idx  = word_index(s_axi_araddr);
      ld_err  = bad_request(s_axi_araddr, s_axi_arsize, s_axi_arburst);
      ld_last = (s_axi_arlen == 8'd0);
    end else begin
      ld_idx  = (r_burst == BURST_INCR) ? r_idx + 1'b1 : r_idx;
      ld_err  = r_err;
      ld_last = ((r_cnt + 8'd1) == r_len);
    end
  end

  // Range is judged per beat: a burst running off the end returns SLVERR
  // only for the beats that are actually outside the array.
  assign ld_ok = !ld_err && in_range(ld_idx);

  // The array is sampled at the load edge, so a write committing on that
  // same edge is not yet visible and the read returns the old word.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= BURST_FIXED;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
      r_last  <= 1'b0;
    end else begin
      if (ar_fire) begin
        r_id    <= s_axi_arid;
        r_len   <= s_axi_arlen;
        r_cnt   <= '0;
        r_burst <= s_axi_arburst;
        r_err   <= ld_err;
      end else if (r_load) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_load) begin
        r_idx  <= ld_idx;
        r_data <= ld_ok ? mem[ld_idx[IDX_WIDTH-1:0]] : '0;
        r_resp <= ld_ok ? RESP_OKAY : RESP_SLVERR;
        r_last <= ld_last;
      end
    end
  end

  assign s_axi_rid   = r_id;
  assign s_axi_rdata = r_data;
  assign s_axi_rresp = r_resp;
  assign s_axi_rlast = r_last;

endmodule

// File: doc/axi4_slave_sram.md
Name: axi4_slave_sram

Overview:
AXI4 slave memory sitting directly downstream of the PicoRV32 AXI4 master. It holds program and data memory in an internal word array. Read and write channels are served by independent state machines, one outstanding transaction each. Single-beat and INCR/FIXED bursts up to 256 beats are supported, with per-byte strobes and SLVERR for illegal or out-of-range accesses.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width (only 32 is supported)
ID_WIDTH, 4, AXI ID width
MEM_WORDS, 1024, number of 32-bit words in the array
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
s_axi_awid / awaddr / awlen / awsize / awburst  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  write address
s_axi_awvalid  in  1; s_axi_awready  out  1
s_axi_wdata / wstrb / wlast  in  DATA_WIDTH / DATA_WIDTH/8 / 1  write data
s_axi_wvalid  in  1; s_axi_wready  out  1
s_axi_bid  out  ID_WIDTH; s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1
s_axi_arid / araddr / arlen / arsize / arburst  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  read address
s_axi_arvalid  in  1; s_axi_arready  out  1
s_axi_rid  out  ID_WIDTH; s_axi_rdata  out  DATA_WIDTH; s_axi_rresp  out  2; s_axi_rlast  out  1; s_axi_rvalid  out  1; s_axi_rready  in  1

Behaviour:
- Clock aclk; reset areset is asynchronous, active-high. On reset all outputs are 0 except awready=1 and arready=1. Both FSMs return to IDLE. Memory contents are retained, not cleared. A reset mid-burst abandons the burst with no B or R response.
- Write FSM states are W_IDLE, W_DATA and W_RESP.
- W_IDLE: awready=1, wready=0. On AW handshake, latch awid, the word index ((awaddr-BASE_ADDR)>>2), awlen, awburst, and an error flag. The error flag is set if awsize!=3'b010, awburst is not FIXED or INCR, or awaddr[1:0]!=0. Next state is W_DATA.
- W_DATA: awready=0, wready=1.
  - Per W handshake: if no error and index<MEM_WORDS, write byte lanes where wstrb[i]=1; otherwise suppress the write and set error (sticky).
  - INCR advances the index by 1; FIXED holds it. The beat counter increments.
  - The burst ends on the beat where counter==awlen, independent of wlast. wlast mismatching the counter sets error.
  - On the final beat go to W_RESP.
- W_RESP: bvalid=1, bid=latched id, bresp=2'b10 if error else 2'b00. Hold until bready, then go to W_IDLE with bvalid=0 on the next cycle.
- AW and W presented in the same cycle: AW accepted in cycle N, W accepted in N+1. The master's W stays valid meanwhile.
- Minimum single-beat write latency: AW handshake in cycle N, W in N+1, bvalid in N+2.
- Read FSM states are R_IDLE and R_DATA.
- R_IDLE: arready=1. On AR handshake, latch id, index, arlen, arburst and the error flag (same rules as write). Go to R_DATA; rvalid=1 in cycle N+1 with registered rdata.
- R_DATA: arready=0.
  - rdata = mem[index], or 0 with rresp=2'b10 if error or index out of range. Range is checked per beat; out-of-range is not sticky on reads.
  - rlast=1 when beat==arlen. rid=latched id.
  - rdata, rresp, rlast and rvalid are held stable while rready=0.
  - On handshake of a non-last beat, advance index (INCR) and counter; the next beat is presented the following cycle, so back-to-back beats are possible with no bubble.
  - On handshake of the last beat, rvalid=0 next cycle and return to R_IDLE.
- Read and write to the same word in the same cycle: the read returns the old data; the write commits at the clock edge.
- Index arithmetic is ADDR_WIDTH wide. An address below BASE_ADDR wraps to a large index and is treated as out of range. No wrap at MEM_WORDS.
- ID is echoed only; no reordering.

Test Plan:
- Write 0xDEADBEEF to 0x10 with wstrb=4'hF, then read 0x10 -> bresp=00; rdata=0xDEADBEEF, rresp=00, rlast=1, rvalid 1 cycle after AR handshake.
- Partial strobe: write 0x000000AA with wstrb=4'b0001 over 0x11223344 -> read returns 0x112233AA.
- INCR read arlen=3 from 0x20 (words 1,2,3,4 preloaded), rready toggled 1,0,1,0 -> 4 beats in order, data held during rready=0, rlast only on beat 4.
- Write to MEM_WORDS*4 (out of range) and a write with awsize=3'b001 -> bresp=2'b10, array unchanged; read at the same address -> rresp=2'b10, rdata=0.
- FIXED write burst awlen=2 to 0x40 with data 1,2,3 -> word 0x40 holds 3; bresp=00. wlast asserted early on beat 2 -> bresp=10.
- Assert areset during beat 2 of a 4-beat read -> rvalid=0 and arready=1 immediately; a subsequent read of 0x10 returns the previously written data.
